simd_mac_acc: RTL and testbench

Pipelined SIMD multiply-accumulate unit that generalises the single-shot SIMD MAC. It computes a dot product of two SIMD_WIDTH-lane vectors per accepted beat and accumulates across a variable number of beats delimited by first/last flags. It delivers one rounded, scaled and optionally saturated result per dot product over a valid/ready output handshake with full backpressure. It sits between the operand-fetch stage and the output/activation writeback in the convolution datapath.

---
 rtl/simd_mac_acc.sv | 186 ++++++++++++++++++
 tb/tb_simd_mac_acc.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/simd_mac_acc.sv
// simd_mac_acc: pipelined SIMD dot-product MAC with multi-beat accumulation,
// round/scale/saturate output stage and valid/ready backpressure.
module simd_mac_acc #(
  parameter int A_WIDTH      = 16,
  parameter int B_WIDTH      = 16,
  parameter int SIMD_WIDTH   = 36,
  parameter int ACC_WIDTH    = 48,
  parameter int OUTPUT_WIDTH = 16,
  parameter int OUTPUT_SCALE = 0,
  parameter int SATURATE     = 1
) (
  input  logic                           clk,
  input  logic                           srst_in,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic                           in_first,
  input  logic                           in_last,
  input  logic signed [A_WIDTH-1:0]      a [0:SIMD_WIDTH-1],
  input  logic signed [B_WIDTH-1:0]      b [0:SIMD_WIDTH-1],
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic signed [OUTPUT_WIDTH-1:0] out,
  output logic                           out_overflow
);
  localparam int PW  = A_WIDTH + B_WIDTH;
  localparam int SW  = PW + $clog2(SIMD_WIDTH);
  localparam int XW  = ACC_WIDTH + 1;
  localparam int RSH = (OUTPUT_SCALE > 0) ? OUTPUT_SCALE - 1 : 0;

  localparam logic signed [XW-1:0] ONE = {{ACC_WIDTH{1'b0}}, 1'b1};
  localparam logic signed [XW-1:0] RND =
    (OUTPUT_SCALE > 0) ? (ONE <<< RSH) : '0;
  localparam logic signed [XW-1:0] OMAX =
    (ONE <<< (OUTPUT_WIDTH - 1)) - ONE;
  localparam logic signed [XW-1:0] OMIN =
    -(ONE <<< (OUTPUT_WIDTH - 1));
  localparam logic signed [ACC_WIDTH-1:0] AMAX =
    {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] AMIN =
    {1'b1, {(ACC_WIDTH-1){1'b0}}};

  logic en;

  logic signed [PW-1:0] s1_prod_q [SIMD_WIDTH];
  logic signed [PW-1:0] s1_prod_d [SIMD_WIDTH];
  logic s1_vld_q, s1_vld_d;
  logic s1_first_q, s1_first_d;
  logic s1_last_q, s1_last_d;

  logic signed [SW-1:0] s2_sum_q, s2_sum_d;
  logic s2_vld_q, s2_vld_d;
  logic s2_first_q, s2_first_d;
  logic s2_last_q, s2_last_d;

  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic ovf_q, ovf_d;
  logic signed [OUTPUT_WIDTH-1:0] out_q, out_d;
  logic out_valid_q, out_valid_d;
  logic out_ovf_q, out_ovf_d;

  logic signed [ACC_WIDTH-1:0] base, acc_next;
  logic signed [XW-1:0] wide, rnd, scaled;
  logic signed [OUTPUT_WIDTH-1:0] res;
  logic ovf_next, clamp;

  assign en           = !out_valid_q || out_ready;
  assign in_ready     = en && !srst_in;
  assign out_valid    = out_valid_q;
  assign out          = out_q;
  assign out_overflow = out_ovf_q;

  always_comb begin
    s1_vld_d   = s1_vld_q;
    s1_first_d = s1_first_q;
    s1_last_d  = s1_last_q;
    for (int i = 0; i < SIMD_WIDTH; i++) begin
      s1_prod_d[i] = s1_prod_q[i];
    end
    if (en) begin
      s1_vld_d   = in_valid;
      s1_first_d = in_first;
      s1_last_d  = in_last;
      for (int i = 0; i < SIMD_WIDTH; i++) begin
        s1_prod_d[i] = PW'(a[i]) * PW'(b[i]);
      end
    end
  end

  always_comb begin
    s2_vld_d   = s2_vld_q;
    s2_first_d = s2_first_q;
    s2_last_d  = s2_last_q;
    s2_sum_d   = s2_sum_q;
    if (en) begin
      s2_vld_d   = s1_vld_q;
      s2_first_d = s1_first_q;
      s2_last_d  = s1_last_q;
      s2_sum_d   = '0;
      for (int i = 0; i < SIMD_WIDTH; i++) begin
        s2_sum_d = s2_sum_d + SW'(s1_prod_q[i]);
      end
    end
  end

  // one guard bit catches accumulator overflow before clamping
  always_comb begin
    base     = s2_first_q ? '0 : acc_q;
    ovf_next = s2_first_q ? 1'b0 : ovf_q;
    wide     = XW'(base) + XW'(s2_sum_q);
    acc_next = wide[ACC_WIDTH-1:0];
    if (wide[XW-1] != wide[XW-2]) begin
      acc_next = wide[XW-1] ? AMIN : AMAX;
      ovf_next = 1'b1;
    end
    rnd    = XW'(acc_next) + RND;
    scaled = rnd >>> OUTPUT_SCALE;
    res    = scaled[OUTPUT_WIDTH-1:0];
    clamp  = 1'b0;
    if (SATURATE != 0) begin
      if (scaled > OMAX) begin
        res   = OMAX[OUTPUT_WIDTH-1:0];
        clamp = 1'b1;
      end else if (scaled < OMIN) begin
        res   = OMIN[OUTPUT_WIDTH-1:0];
        clamp = 1'b1;
      end
    end
  end

  always_comb begin
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    out_d       = out_q;
    out_ovf_d   = out_ovf_q;
    out_valid_d = out_valid_q && !out_ready;
    if (en && s2_vld_q) begin
      if (s2_last_q) begin
        acc_d       = '0;
        ovf_d       = 1'b0;
        out_d       = res;
        out_ovf_d   = ovf_next | clamp;
        out_valid_d = 1'b1;
      end else begin
        acc_d = acc_next;
        ovf_d = ovf_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (srst_in) begin
      for (int i = 0; i < SIMD_WIDTH; i++) begin
        s1_prod_q[i] <= '0;
      end
      s1_vld_q    <= 1'b0;
      s1_first_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s2_sum_q    <= '0;
      s2_vld_q    <= 1'b0;
      s2_first_q  <= 1'b0;
      s2_last_q   <= 1'b0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      out_ovf_q   <= 1'b0;
    end else begin
      for (int i = 0; i < SIMD_WIDTH; i++) begin
        s1_prod_q[i] <= s1_prod_d[i];
      end
      s1_vld_q    <= s1_vld_d;
      s1_first_q  <= s1_first_d;
      s1_last_q   <= s1_last_d;
      s2_sum_q    <= s2_sum_d;
      s2_vld_q    <= s2_vld_d;
      s2_first_q  <= s2_first_d;
      s2_last_q   <= s2_last_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

endmodule

// File: tb/tb_simd_mac_acc.sv
// tb_simd_mac_acc: four parameterisations share one beat stream; a
// dot-product model predicts every result, directed literals pin it.
module tb_simd_mac_acc;
  logic clk = 1'b0;
  logic srst_in, in_valid, in_first, in_last, out_ready;
  logic signed [15:0] a_m [0:35];
  logic signed [15:0] b_m [0:35];
  logic signed [15:0] a1 [0:0];
  logic signed [15:0] b1 [0:0];
  logic rdy0, rdy1, rdy2, rdy3;
  logic vld0, vld1, vld2, vld3;
  logic ovf0, ovf1, ovf2, ovf3;
  logic signed [15:0] out0, out1;
  logic signed [7:0]  out2;
  logic signed [32:0] out3;

  int checks = 0;
  int errors = 0;

  int nl_p [4] = '{36, 1, 1, 1};
  int aw_p [4] = '{48, 48, 48, 33};
  int sc_p [4] = '{0, 2, 0, 0};
  int st_p [4] = '{1, 1, 0, 1};
  int ow_p [4] = '{16, 16, 8, 33};

  typedef struct packed {
    logic [3:0][63:0] v;
    logic [3:0]       o;
  } exp_t;

  exp_t   q [$];
  longint mdl_acc [4];
  bit     mdl_ovf [4];

  assign a1[0] = a_m[0];
  assign b1[0] = b_m[0];

  always #5 clk = ~clk;

  simd_mac_acc u0 (
    .clk(clk), .srst_in(srst_in), .in_valid(in_valid), .in_ready(rdy0),
    .in_first(in_first), .in_last(in_last), .a(a_m), .b(b_m),
    .out_valid(vld0), .out_ready(out_ready), .out(out0),
    .out_overflow(ovf0));

  simd_mac_acc #(.SIMD_WIDTH(1), .OUTPUT_SCALE(2)) u1 (
    .clk(clk), .srst_in(srst_in), .in_valid(in_valid), .in_ready(rdy1),
    .in_first(in_first), .in_last(in_last), .a(a1), .b(b1),
    .out_valid(vld1), .out_ready(out_ready), .out(out1),
    .out_overflow(ovf1));

  simd_mac_acc #(.SIMD_WIDTH(1), .SATURATE(0), .OUTPUT_WIDTH(8)) u2 (
    .clk(clk), .srst_in(srst_in), .in_valid(in_valid), .in_ready(rdy2),
    .in_first(in_first), .in_last(in_last), .a(a1), .b(b1),
    .out_valid(vld2), .out_ready(out_ready), .out(out2),
    .out_overflow(ovf2));

  simd_mac_acc #(.SIMD_WIDTH(1), .ACC_WIDTH(33), .OUTPUT_WIDTH(33)) u3 (
    .clk(clk), .srst_in(srst_in), .in_valid(in_valid), .in_ready(rdy3),
    .in_first(in_first), .in_last(in_last), .a(a1), .b(b1),
    .out_valid(vld3), .out_ready(out_ready), .out(out3),
    .out_overflow(ovf3));

  task automatic chk(input string nm, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  function automatic longint dut_out(input int d);
    case (d)
      0: return longint'(out0);
      1: return longint'(out1);
      2: return longint'(out2);
      default: return longint'(out3);
    endcase
  endfunction

  function automatic bit dut_ovf(input int d);
    case (d)
      0: return ovf0;
      1: return ovf1;
      2: return ovf2;
      default: return ovf3;
    endcase
  endfunction

  function automatic void shape(input longint acc, input int d,
                                output longint v, output bit c);
    longint r, hi, lo;
    r = acc;
    c = 1'b0;
    if (sc_p[d] > 0) r = (r + (longint'(1) << (sc_p[d] - 1))) >>> sc_p[d];
    hi = (longint'(1) << (ow_p[d] - 1)) - 1;
    lo = -hi - 1;
    if (st_p[d] != 0) begin
      if (r > hi) begin r = hi; c = 1'b1; end
      else if (r < lo) begin r = lo; c = 1'b1; end
    end else begin
      r = (r << (64 - ow_p[d])) >>> (64 - ow_p[d]);
    end
    v = r;
  endfunction

  // reference: accumulate each accepted beat, queue the shaped result
  always @(posedge clk) begin
    longint dot, lim, v;
    bit c;
    exp_t e;
    if (srst_in) begin
      q.delete();
      for (int d = 0; d < 4; d++) begin
        mdl_acc[d] = 0;
        mdl_ovf[d] = 1'b0;
      end
    end else if (in_valid && rdy0) begin
      e = '0;
      for (int d = 0; d < 4; d++) begin
        dot = 0;
        for (int i = 0; i < nl_p[d]; i++)
          dot += longint'(a_m[i]) * longint'(b_m[i]);
        if (in_first) begin
          mdl_acc[d] = 0;
          mdl_ovf[d] = 1'b0;
        end
        mdl_acc[d] += dot;
        lim = longint'(1) << (aw_p[d] - 1);
        if (mdl_acc[d] > lim - 1) begin
          mdl_acc[d] = lim - 1;
          mdl_ovf[d] = 1'b1;
        end else if (mdl_acc[d] < -lim) begin
          mdl_acc[d] = -lim;
          mdl_ovf[d] = 1'b1;
        end
        if (in_last) begin
          shape(mdl_acc[d], d, v, c);
          e.v[d] = v;
          e.o[d] = mdl_ovf[d] | c;
          mdl_acc[d] = 0;
          mdl_ovf[d] = 1'b0;
        end
      end
      if (in_last) q.push_back(e);
    end
  end

  logic        stall_prev = 1'b0;
  logic [15:0] prev_out;
  logic        prev_ovf;

  always @(negedge clk) begin
    exp_t e;
    longint ev;
    if (!srst_in) begin
      chk("valid_agree", {vld3, vld2, vld1, vld0}, {4{vld0}});
      chk("ready_agree", {rdy3, rdy2, rdy1, rdy0}, {4{rdy0}});
      if (stall_prev) begin
        chk("hold_valid", vld0, 1);
        chk("hold_out", out0, $signed(prev_out));
        chk("hold_ovf", ovf0, prev_ovf);
      end
      if (vld0 && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          e = q.pop_front();
          for (int d = 0; d < 4; d++) begin
            ev = e.v[d];
            chk($sformatf("out_d%0d", d), dut_out(d), ev);
            chk($sformatf("ovf_d%0d", d), dut_ovf(d), e.o[d]);
          end
        end
      end
    end
    stall_prev = !srst_in && vld0 && !out_ready;
    prev_out   = out0;
    prev_ovf   = ovf0;
  end

  task automatic beat(input bit f, input bit l, input int av, input int bv,
                      input int rp);
    bit ok;
    int n;
    in_first = f;
    in_last  = l;
    in_valid = 1'b1;
    for (int i = 0; i < 36; i++) begin
      a_m[i] = 16'(av + rp * i);
      b_m[i] = 16'(bv);
    end
    n = 0;
    do begin
      @(negedge clk);
      ok = rdy0;
      @(posedge clk);
      n++;
    end while (!ok && n < 100);
    if (!ok) chk("accept_timeout", 0, 1);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_out(input string nm);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!vld0 && n < 20);
    if (!vld0) chk(nm, 0, 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || vld0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain", q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic signed [15:0] hold_v;
    srst_in   = 1'b1;
    in_valid  = 1'b0;
    in_first  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 36; i++) begin
      a_m[i] = '0;
      b_m[i] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", vld0, 0);
    chk("rst_out", out0, 0);
    chk("rst_ovf", ovf0, 0);
    chk("rst_in_ready", rdy0, 0);
    @(posedge clk);
    #1 srst_in = 1'b0;

    // three beats of 36 lanes of 1*2; exact latency and one-cycle valid
    beat(1, 0, 1, 2, 0);
    beat(0, 0, 1, 2, 0);
    beat(0, 1, 1, 2, 0);
    @(negedge clk);
    chk("lat_t1", vld0, 0);
    @(negedge clk);
    chk("lat_t2", vld0, 0);
    @(negedge clk);
    chk("lat_t3", vld0, 1);
    chk("dot216", out0, 216);
    chk("dot216_ovf", ovf0, 0);
    @(negedge clk);
    chk("lat_t4", vld0, 0);
    drain();

    beat(1, 1, 32767, 32767, 0);
    wait_out("pos_sat_timeout");
    chk("pos_sat", out0, 32767);
    chk("pos_sat_ovf", ovf0, 1);
    drain();
    beat(1, 1, -32768, 32767, 0);
    wait_out("neg_sat_timeout");
    chk("neg_sat", out0, -32768);
    chk("neg_sat_ovf", ovf0, 1);
    drain();

    beat(1, 1, 7, 1, 0);
    wait_out("rnd_pos_timeout");
    chk("rnd_pos", out1, 2);
    drain();
    beat(1, 1, -7, 1, 0);
    wait_out("rnd_neg_timeout");
    chk("rnd_neg", out1, -2);
    drain();
    beat(1, 1, 300, 1, 0);
    wait_out("trunc_timeout");
    chk("trunc", out2, 44);
    chk("trunc_ovf", ovf2, 0);
    drain();

    // backpressure while single-beat results stream back to back
    fork
      begin
        for (int k = 0; k < 6; k++) beat(1, 1, k + 1, 1, 1);
      end
      begin
        int n;
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!vld0 && n < 30);
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        hold_v = out0;
        repeat (5) begin
          @(negedge clk);
          chk("stall_in_ready", rdy0, 0);
          chk("stall_valid", vld0, 1);
          chk("stall_hold", out0, hold_v);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    for (int k = 0; k < 6; k++) beat(k == 0, k == 5, 32767, 32767, 0);
    wait_out("acc_clamp_timeout");
    chk("acc_clamp", out3, 64'sd4294967295);
    chk("acc_clamp_ovf", ovf3, 1);
    chk("acc_clamp_main", out0, 32767);
    drain();
    beat(1, 1, 1, 1, 0);
    wait_out("ovf_clear_timeout");
    chk("ovf_clear", out3, 1);
    chk("ovf_clear_flag", ovf3, 0);
    drain();

    // reset mid dot product drops the partial sum
    beat(1, 0, 3, 3, 0);
    beat(0, 0, 3, 3, 0);
    srst_in = 1'b1;
    @(negedge clk);
    chk("rst_pulse_ready", rdy0, 0);
    @(posedge clk);
    #1 srst_in = 1'b0;
    repeat (6) begin
      @(negedge clk);
      chk("rst_no_out", vld0, 0);
    end
    @(posedge clk);
    #1;
    beat(1, 1, 1, 1, 0);
    wait_out("post_rst_timeout");
    chk("post_rst", out0, 36);
    chk("post_rst_ovf", ovf0, 0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
